// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit.
// Holds the access FSM state encoding, funct3 size codes, mem_m bit
// positions and small decode helpers used by the top and its sub-module.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RSP,
    ST_DONE
  } mau_state_e;

  // Bit positions inside the 3-bit MEM control bundle.
  localparam int MEM_M_READ   = 2;
  localparam int MEM_M_WRITE  = 1;
  localparam int MEM_M_BRANCH = 0;

  // funct3 codes; [1:0] is log2 of the access size in bytes.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Loads accept every code except 111; stores only the signed-size codes.
  function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
    if (is_load) return (f3 != 3'b111);
    return (f3[2] == 1'b0);
  endfunction

  // Offset must be a multiple of the access size.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [2:0] off);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      2'b10:   return |off[1:0];
      default: return |off;
    endcase
  endfunction

  // Byte-enable mask for an access at offset 0.
  function automatic logic [7:0] f3_strb(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 8'h01;
      2'b01:   return 8'h03;
      2'b10:   return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus between the MEM-stage access unit
// (master) and the data memory (slave).
//   dmem_req_valid/ready : request handshake
//   dmem_we              : 1 = store, 0 = load
//   dmem_addr            : 8-byte aligned address
//   dmem_wdata/wstrb     : lane-positioned store data and byte enables
//   dmem_rsp_valid/rdata : load response (aligned 64-bit word)
interface mem_access_unit_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [7:0]        dmem_wstrb;
  logic              dmem_rsp_valid;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_req_ready, dmem_rsp_valid, dmem_rdata
  );
endinterface

// File: rtl/mem_load_extend.sv
// Combinational load alignment: moves the addressed bytes of the aligned
// memory word down to bit 0 and sign- or zero-extends them per funct3.
//   i_rdata  : aligned word from data memory
//   i_offset : byte offset inside the word (addr[2:0])
//   i_funct3 : load size/sign code
//   o_data   : extended load result
module mem_load_extend
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [2:0]        i_offset,
  input  logic [2:0]        i_funct3,
  output logic [DATA_W-1:0] o_data
);

  logic        [DATA_W-1:0] w_shifted;
  logic signed [7:0]        w_b;
  logic signed [15:0]       w_h;
  logic signed [31:0]       w_w;

  assign w_shifted = i_rdata >> {i_offset, 3'b000};
  assign w_b       = w_shifted[7:0];
  assign w_h       = w_shifted[15:0];
  assign w_w       = w_shifted[31:0];

  always_comb begin
    o_data = w_shifted;
    case (i_funct3)
      F3_B:    o_data = {{(DATA_W-8){w_b[7]}}, w_b};
      F3_H:    o_data = {{(DATA_W-16){w_h[15]}}, w_h};
      F3_W:    o_data = {{(DATA_W-32){w_w[31]}}, w_w};
      F3_D:    o_data = w_shifted;
      F3_BU:   o_data = {{(DATA_W-8){1'b0}}, w_b};
      F3_HU:   o_data = {{(DATA_W-16){1'b0}}, w_h};
      F3_WU:   o_data = {{(DATA_W-32){1'b0}}, w_w};
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit. Decodes the MEM-stage instruction,
// rejects misaligned/illegal accesses with a one-cycle access_fault, and
// otherwise runs one request (and, for loads, one response) on the data
// memory bus while stalling the earlier pipeline stages.
//   clk, rst       : clock, asynchronous active-low reset
//   mem_valid      : MEM slot holds a real instruction
//   mem_m          : [2]=read, [1]=write, [0]=branch (unused here)
//   mem_inst       : instruction (funct3 in [14:12])
//   mem_alu_result : effective byte address
//   mem_rs2_data   : store data
//   dmem           : data-memory bus (master side)
//   stall          : freeze PC and pipeline registers up to EX/MEM
//   load_data      : extended load result, held until the next load
//   load_valid     : one-cycle pulse when load_data is updated
//   access_fault   : one-cycle pulse on misaligned or illegal access
// Only DATA_W = 64 is supported (8 byte lanes).
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_valid,
  input  logic [2:0]           mem_m,
  input  logic [31:0]          mem_inst,
  input  logic [ADDR_W-1:0]    mem_alu_result,
  input  logic [DATA_W-1:0]    mem_rs2_data,
  mem_access_unit_if.master    dmem,
  output logic                 stall,
  output logic [DATA_W-1:0]    load_data,
  output logic                 load_valid,
  output logic                 access_fault
);

  mau_state_e          r_state;
  logic                r_req_valid;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [7:0]          r_wstrb;
  logic [2:0]          r_offset;
  logic [2:0]          r_funct3;
  logic [DATA_W-1:0]   r_load_data;
  logic                r_load_valid;

  logic [2:0]          w_funct3;
  logic [2:0]          w_offset;
  logic                w_is_load;
  logic                w_is_store;
  logic                w_access;
  logic                w_bad;
  logic                w_start;
  logic [DATA_W-1:0]   w_load_ext;
  logic                w_unused_bits;

  assign w_funct3   = mem_inst[14:12];
  assign w_offset   = mem_alu_result[2:0];
  // Read wins when both control bits are set.
  assign w_is_load  = mem_valid & mem_m[MEM_M_READ];
  assign w_is_store = mem_valid & mem_m[MEM_M_WRITE] & ~mem_m[MEM_M_READ];
  assign w_access   = w_is_load | w_is_store;
  assign w_bad      = w_access &
                      (~f3_legal(w_is_load, w_funct3) | f3_misaligned(w_funct3, w_offset));
  assign w_start    = w_access & ~w_bad;

  assign w_unused_bits = ^{mem_inst[31:15], mem_inst[11:0], mem_m[MEM_M_BRANCH]};

  mem_load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .i_rdata  (dmem.dmem_rdata),
    .i_offset (r_offset),
    .i_funct3 (r_funct3),
    .o_data   (w_load_ext)
  );

  // Stall must rise in the very cycle a legal access is seen in IDLE, so it
  // is decoded from state; the rst term keeps it low while reset is held.
  assign stall = rst & (((r_state == ST_IDLE) & w_start) |
                        (r_state == ST_REQ) | (r_state == ST_WAIT_RSP));
  // Faults are only raised from IDLE; the instruction is not stalled, so the
  // pulse lasts the single cycle it spends in MEM.
  assign access_fault = rst & (r_state == ST_IDLE) & w_bad;

  assign dmem.dmem_req_valid = r_req_valid;
  assign dmem.dmem_we        = r_we;
  assign dmem.dmem_addr      = r_addr;
  assign dmem.dmem_wdata     = r_wdata;
  assign dmem.dmem_wstrb     = r_wstrb;
  assign load_data           = r_load_data;
  assign load_valid          = r_load_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_req_valid  <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_offset     <= '0;
      r_funct3     <= '0;
      r_load_data  <= '0;
      r_load_valid <= 1'b0;
    end else begin
      r_load_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_addr      <= {mem_alu_result[ADDR_W-1:3], 3'b000};
            r_we        <= w_is_store;
            r_wdata     <= w_is_store ? (mem_rs2_data << {w_offset, 3'b000}) : '0;
            r_wstrb     <= w_is_store ? (f3_strb(w_funct3) << w_offset) : 8'h00;
            r_offset    <= w_offset;
            r_funct3    <= w_funct3;
            r_req_valid <= 1'b1;
            r_state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Request fields stay frozen in their registers until accepted.
          if (dmem.dmem_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= r_we ? ST_DONE : ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
          if (dmem.dmem_rsp_valid) begin
            r_load_data  <= w_load_ext;
            r_load_valid <= 1'b1;
            r_state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Stall drops here so the pipeline moves the instruction on;
          // returning to IDLE unconditionally prevents a re-issue.
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_W, default 64, SHALL set the byte-address width of mem_alu_result and dmem_addr.
REQ-002 Parameter DATA_W, default 64, SHALL set the data-memory word width; only 64 is supported.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 mem_valid  in  1  MEM-stage slot holds a real instruction, not a bubble.
REQ-007 mem_m  in  3  MEM control: [2]=mem_read, [1]=mem_write, [0]=branch (ignored here).
REQ-008 mem_inst  in  32  MEM-stage instruction; funct3 = mem_inst[14:12].
REQ-009 mem_alu_result  in  ADDR_W  effective byte address.
REQ-010 mem_rs2_data  in  64  store data.
REQ-011 dmem_req_valid  out  1  request valid to data memory.
REQ-012 dmem_req_ready  in  1  data memory accepts the request.
REQ-013 dmem_we  out  1  1=store, 0=load.
REQ-014 dmem_addr  out  ADDR_W  8-byte-aligned address {addr[ADDR_W-1:3],3'b000}.
REQ-015 dmem_wdata  out  64  store data shifted left by addr[2:0]*8.
REQ-016 dmem_wstrb  out  8  byte enables; size mask shifted left by addr[2:0].
REQ-017 dmem_rsp_valid  in  1  load data valid.
REQ-018 dmem_rdata  in  64  load data, aligned word.
REQ-019 stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM registers.
REQ-020 load_data  out  64  aligned, extended load result.
REQ-021 load_valid  out  1  one-cycle pulse; load_data is valid.
REQ-022 access_fault  out  1  one-cycle pulse on a misaligned access or an illegal funct3.

Function
REQ-023 FSM states SHALL be IDLE, REQ, WAIT_RSP, DONE.
REQ-024 An access SHALL start in IDLE when mem_valid=1 and mem_read or mem_write is set; mem_read SHALL win if both are set.
REQ-025 Sizes SHALL be: load funct3 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU; store funct3 000 SB, 001 SH, 010 SW, 011 SD; any other funct3 is illegal.
REQ-026 An access is misaligned when addr[2:0] is not a multiple of the access size.
REQ-027 A misaligned or illegal access SHALL pulse access_fault for one cycle in IDLE, issue no request and keep stall low.
REQ-028 IDLE with a legal access: stall=1 combinationally; register addr, we, wdata and wstrb; go to REQ.
REQ-029 REQ: dmem_req_valid=1 and request fields held stable until dmem_req_ready=1; a store then goes to DONE and a load to WAIT_RSP.
REQ-030 WAIT_RSP: stall=1; on dmem_rsp_valid=1, shift dmem_rdata right by offset*8, sign- or zero-extend per funct3 into load_data, and go to DONE.
REQ-031 dmem_rsp_valid SHALL be ignored outside WAIT_RSP.
REQ-032 DONE: stall=0 and load_valid=1 (loads only); go unconditionally to IDLE so the same instruction never re-issues.
REQ-033 Latency: a store with ready=1 spends 3 cycles in MEM (2 stalled); a load with ready=1 and the response one cycle later spends 4 cycles (3 stalled).
REQ-034 Non-memory instructions and bubbles SHALL keep stall=0 and produce no request.
REQ-035 load_data SHALL hold its value until the next load completes.

Reset
REQ-036 rst=0 SHALL immediately force state IDLE and drive dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, load_data, load_valid, access_fault and stall to 0.
REQ-037 Reset mid-operation SHALL abandon the access; a late dmem_rsp_valid arriving in IDLE SHALL be discarded.

Structure
REQ-038 A shared package SHALL hold the state enum, funct3 size constants and mem_m bit indices.
REQ-039 Load shift/extension SHALL be a combinational sub-module, mem_load_extend.

Verification
REQ-040 SD at addr 0x1008, rs2=0x1122334455667788, ready=1 -> dmem_addr=0x1008, wstrb=0xFF, we=1; stall high for 2 cycles.
REQ-041 LB at addr 0x2003, rdata=0x00000000_80000000 -> load_data=0xFFFFFFFFFFFFFF80; LBU on the same data -> 0x80.
REQ-042 SH at addr 0x3006, rs2=0xABCD -> wstrb=0xC0, wdata[63:48]=0xABCD.
REQ-043 LW at addr 0x4002 -> access_fault pulses once, dmem_req_valid stays 0, stall stays 0.
REQ-044 LD with ready held low 5 cycles, then response 2 cycles after accept -> request fields stable throughout, stall high for 9 cycles, load_valid pulses once.
REQ-045 rst asserted in WAIT_RSP, then rsp_valid after release -> load_valid stays 0 and state is IDLE.
